// File: rtl/display_scanner.sv
// display_scanner
// Drives a 6-digit multiplexed seven-segment display that shows HH.MM.SS
// from the clock core's binary time fields. One digit is enabled at a time
// and each digit is held for DIGIT_DIV cycles. The time fields are captured
// once per frame, so the tens and ones of a field always match. When a
// field is being edited, its two digits blink.
//
// Ports:
//   clk      - system clock; all state changes on the rising edge
//   reset    - asynchronous, active-low reset (0 = reset)
//   sec_in   - binary seconds (values above 59 are shown as dashes)
//   min_in   - binary minutes (values above 59 are shown as dashes)
//   hour_in  - binary hours (values above 23 are shown as dashes)
//   select   - field under edit: `SELECT_SEC, `SELECT_MIN or `SELECT_HOUR;
//              any other code selects no field
//   edit_en  - 1 = blink the selected field
//   seg_out  - active-high segments, bit0 = a ... bit6 = g (registered)
//   dp_out   - active-high decimal point after the MM and HH ones digits
//              (registered)
//   an_out   - active-low one-hot digit enable, bit0 = seconds ones ...
//              bit5 = hours tens (registered)

`ifndef SELECT_SEC
`define SELECT_SEC  2'd1
`endif
`ifndef SELECT_MIN
`define SELECT_MIN  2'd2
`endif
`ifndef SELECT_HOUR
`define SELECT_HOUR 2'd3
`endif

module display_scanner #(
  parameter int CLK_FREQ_HZ = 1000,
  parameter int DIGIT_HZ    = 500,
  parameter int BLINK_HZ    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] sec_in,
  input  logic [5:0] min_in,
  input  logic [4:0] hour_in,
  input  logic [1:0] select,
  input  logic       edit_en,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic [5:0] an_out
);

  localparam int DIGIT_DIV = CLK_FREQ_HZ / DIGIT_HZ;
  localparam int BLINK_DIV = CLK_FREQ_HZ / (2 * BLINK_HZ);
  localparam int DIGIT_W   = (DIGIT_DIV > 1) ? $clog2(DIGIT_DIV) : 1;
  localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(DIGIT_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [6:0]         SEG_DASH   = 7'h40;

  logic [DIGIT_W-1:0] digit_cnt;
  logic [2:0]         digit_idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_on;
  logic [5:0]         sec_snap;
  logic [5:0]         min_snap;
  logic [4:0]         hour_snap;
  logic               first_cycle;
  logic [1:0]         select_prev;
  logic               edit_prev;

  logic               digit_wrap;
  logic               frame_wrap;
  logic               capture;
  logic               restart;
  logic               blink_wrap;
  logic [BLINK_W-1:0] blink_cnt_next;
  logic               blink_on_next;
  logic [6:0]         seg_next;
  logic [5:0]         field_mask;
  logic [5:0]         an_next;
  logic               dp_next;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h3F;
      4'd1:    seg_code = 7'h06;
      4'd2:    seg_code = 7'h5B;
      4'd3:    seg_code = 7'h4F;
      4'd4:    seg_code = 7'h66;
      4'd5:    seg_code = 7'h6D;
      4'd6:    seg_code = 7'h7D;
      4'd7:    seg_code = 7'h07;
      4'd8:    seg_code = 7'h7F;
      4'd9:    seg_code = 7'h6F;
      default: seg_code = SEG_DASH;
    endcase
  endfunction

  // An out-of-range field shows a dash on both of its digits, never a
  // half-decoded number.
  function automatic logic [6:0] field_seg(input logic [5:0] v,
                                           input logic [5:0] max_v,
                                           input logic       tens);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 6'd10);
    o = 4'(v % 6'd10);
    if (v > max_v)
      field_seg = SEG_DASH;
    else if (tens)
      field_seg = seg_code(t);
    else
      field_seg = seg_code(o);
  endfunction

  // The first clock after reset is not treated as a select/edit change:
  // there is no earlier value to compare against. On a restart, the divider
  // and the phase are reloaded together. This makes the field visible on
  // the same edge that the operator steps to it.
  always_comb begin
    digit_wrap = (digit_cnt == DIGIT_LAST);
    frame_wrap = digit_wrap && (digit_idx == 3'd5);
    capture    = frame_wrap || first_cycle;
    restart    = !first_cycle &&
                 ((select != select_prev) || (edit_en && !edit_prev));
    blink_wrap = (blink_cnt == BLINK_LAST);
    if (restart) begin
      blink_cnt_next = '0;
      blink_on_next  = 1'b1;
    end else if (blink_wrap) begin
      blink_cnt_next = '0;
      blink_on_next  = ~blink_on;
    end else begin
      blink_cnt_next = blink_cnt + 1'b1;
      blink_on_next  = blink_on;
    end
  end

  // The digit is decoded from the snapshot only, so the live inputs never
  // reach the display in the middle of a frame. Blanking uses the phase that
  // is registered on this same edge, so the blink starts and stops together
  // with the blink phase.
  always_comb begin
    seg_next = 7'h00;
    case (digit_idx)
      3'd0:    seg_next = field_seg(sec_snap, 6'd59, 1'b0);
      3'd1:    seg_next = field_seg(sec_snap, 6'd59, 1'b1);
      3'd2:    seg_next = field_seg(min_snap, 6'd59, 1'b0);
      3'd3:    seg_next = field_seg(min_snap, 6'd59, 1'b1);
      3'd4:    seg_next = field_seg({1'b0, hour_snap}, 6'd23, 1'b0);
      3'd5:    seg_next = field_seg({1'b0, hour_snap}, 6'd23, 1'b1);
      default: seg_next = 7'h00;
    endcase

    field_mask = 6'b000000;
    if (edit_en && !blink_on_next) begin
      case (select)
        `SELECT_SEC:  field_mask = 6'b000011;
        `SELECT_MIN:  field_mask = 6'b001100;
        `SELECT_HOUR: field_mask = 6'b110000;
        default:      field_mask = 6'b000000;
      endcase
    end

    an_next = ~(6'b000001 << digit_idx) | field_mask;
    dp_next = (digit_idx == 3'd2) || (digit_idx == 3'd4);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit_cnt   <= '0;
      digit_idx   <= 3'd0;
      blink_cnt   <= '0;
      blink_on    <= 1'b1;
      sec_snap    <= 6'd0;
      min_snap    <= 6'd0;
      hour_snap   <= 5'd0;
      first_cycle <= 1'b1;
      select_prev <= 2'd0;
      edit_prev   <= 1'b0;
      seg_out     <= 7'h00;
      an_out      <= 6'b111111;
      dp_out      <= 1'b0;
    end else begin
      first_cycle <= 1'b0;
      select_prev <= select;
      edit_prev   <= edit_en;

      if (digit_wrap) begin
        digit_cnt <= '0;
        digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
      end else begin
        digit_cnt <= digit_cnt + 1'b1;
      end

      blink_cnt <= blink_cnt_next;
      blink_on  <= blink_on_next;

      if (capture) begin
        sec_snap  <= sec_in;
        min_snap  <= min_in;
        hour_snap <= hour_in;
      end

      seg_out <= seg_next;
      an_out  <= an_next;
      dp_out  <= dp_next;
    end
  end

endmodule
